// File: rtl/sudoku_pkg.sv
// Shared types and size helpers for the parametrised Sudoku grid checker.
// The scan order and error encodings live here so the checker and its tracker agree.
package sudoku_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ROWS   = 3'd1,
        ST_COLS   = 3'd2,
        ST_BOXES  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_ROW   = 2'd0,
        ERR_COL   = 2'd1,
        ERR_BOX   = 2'd2,
        ERR_VALUE = 2'd3
    } err_kind_t;

    function automatic int side_of(input int box_dim);
        return box_dim * box_dim;
    endfunction

    // Width of a counter that runs 0..box_dim-1; never narrower than one bit.
    function automatic int dim_w(input int box_dim);
        return (box_dim <= 2) ? 1 : $clog2(box_dim);
    endfunction

endpackage

// File: rtl/sudoku_dup_tracker.sv
// Seen-mask tracker for one row, column or box at a time.
// Flags a repeated digit and any value that is not a legal digit.
module sudoku_dup_tracker
    import sudoku_pkg::*;
#(
    parameter int BOX_DIM = 3,
    parameter int CELL_W  = 4
) (
    input  logic              clk,
    input  logic              valid,
    input  logic              first,
    input  logic [CELL_W-1:0] value,
    output logic              dup,
    output logic              illegal
);

    localparam int SIDE = side_of(BOX_DIM);

    logic [SIDE-1:0] mask_q;
    logic [SIDE-1:0] onehot;

    // Zero and out-of-range values decode to an empty one-hot, so they never mark the mask.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < SIDE; i++) begin
            onehot[i] = (value == CELL_W'(i + 1));
        end
    end

    assign illegal = valid && (value > CELL_W'(SIDE));
    assign dup     = valid && !first && (|(mask_q & onehot));

    // The first cell of a unit overwrites the mask, which doubles as the clear.
    always_ff @(posedge clk) begin
        if (valid) begin
            mask_q <= first ? onehot : (mask_q | onehot);
        end
    end

endmodule

// File: rtl/sudoku_grid_checker.sv
// SIDE x SIDE Sudoku grid store with a one-cell-per-cycle legality scan over
// rows, then columns, then boxes; the first violation found is reported.
module sudoku_grid_checker
    import sudoku_pkg::*;
#(
    parameter int BOX_DIM = 3,
    parameter int CELL_W  = 4,
    parameter int IDX_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    input  logic [CELL_W-1:0] load_value,
    output logic              load_ready,
    input  logic              load_restart,
    input  logic              check_start,
    input  logic              check_full,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_kind,
    output logic [IDX_W-1:0]  err_row,
    output logic [IDX_W-1:0]  err_col
);

    localparam int               SIDE = side_of(BOX_DIM);
    localparam int               DW   = dim_w(BOX_DIM);
    localparam logic [DW-1:0]    DMAX = DW'(BOX_DIM - 1);
    localparam logic [IDX_W-1:0] BD_I = IDX_W'(BOX_DIM);
    localparam logic [IDX_W-1:0] SMAX = IDX_W'(SIDE - 1);

    state_t            state_q, state_d;
    logic [CELL_W-1:0] grid_q [SIDE][SIDE];
    logic [IDX_W-1:0]  cur_row_q, cur_col_q;

    // Unit index u = uh*BOX_DIM + ul, element index k = kh*BOX_DIM + kl.
    logic [DW-1:0]     uh_q, ul_q, kh_q, kl_q;

    logic              full_q;
    logic              error_q;
    err_kind_t         err_kind_q, kind_d;
    logic [IDX_W-1:0]  err_row_q, err_col_q;

    logic              scanning;
    logic              start_ok;
    logic              load_ok;
    logic              first_cell;
    logic              last_cell;
    logic              illegal_here;
    logic              viol;
    logic [IDX_W-1:0]  u_idx, k_idx, box_row, box_col;
    logic [IDX_W-1:0]  scan_row, scan_col;
    logic [CELL_W-1:0] cell_val;
    logic              trk_dup, trk_illegal;

    assign start_ok = check_start && !scanning;
    assign load_ok  = load_valid && !scanning && !load_restart;

    // ---- load path: cursor and grid storage ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_row_q <= '0;
            cur_col_q <= '0;
        end else if (load_restart) begin
            cur_row_q <= '0;
            cur_col_q <= '0;
        end else if (load_ok) begin
            if (cur_col_q == SMAX) begin
                cur_col_q <= '0;
                cur_row_q <= (cur_row_q == SMAX) ? '0 : cur_row_q + 1'b1;
            end else begin
                cur_col_q <= cur_col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < SIDE; r++) begin
                for (int c = 0; c < SIDE; c++) begin
                    grid_q[r][c] <= '0;
                end
            end
        end else if (load_ok) begin
            grid_q[cur_row_q][cur_col_q] <= load_value;
        end
    end

    // ---- scan counters: nested BOX_DIM-radix digits, last digit wraps the phase ----
    always_ff @(posedge clk) begin
        if (!rst_n || start_ok) begin
            uh_q <= '0;
            ul_q <= '0;
            kh_q <= '0;
            kl_q <= '0;
        end else if (scanning) begin
            if (kl_q != DMAX) begin
                kl_q <= kl_q + 1'b1;
            end else begin
                kl_q <= '0;
                if (kh_q != DMAX) begin
                    kh_q <= kh_q + 1'b1;
                end else begin
                    kh_q <= '0;
                    if (ul_q != DMAX) begin
                        ul_q <= ul_q + 1'b1;
                    end else begin
                        ul_q <= '0;
                        uh_q <= (uh_q == DMAX) ? '0 : uh_q + 1'b1;
                    end
                end
            end
        end
    end

    assign first_cell = (kh_q == '0) && (kl_q == '0);
    assign last_cell  = (uh_q == DMAX) && (ul_q == DMAX) && (kh_q == DMAX) && (kl_q == DMAX);

    assign u_idx   = IDX_W'(uh_q) * BD_I + IDX_W'(ul_q);
    assign k_idx   = IDX_W'(kh_q) * BD_I + IDX_W'(kl_q);
    assign box_row = IDX_W'(uh_q) * BD_I + IDX_W'(kh_q);
    assign box_col = IDX_W'(ul_q) * BD_I + IDX_W'(kl_q);

    always_comb begin
        scan_row = box_row;
        scan_col = box_col;
        case (state_q)
            ST_ROWS: begin
                scan_row = u_idx;
                scan_col = k_idx;
            end
            ST_COLS: begin
                scan_row = k_idx;
                scan_col = u_idx;
            end
            default: ;
        endcase
    end

    assign cell_val = grid_q[scan_row][scan_col];

    // ---- cell check: duplicate and value legality, same cycle as the read ----
    sudoku_dup_tracker #(
        .BOX_DIM (BOX_DIM),
        .CELL_W  (CELL_W)
    ) u_tracker (
        .clk     (clk),
        .valid   (scanning),
        .first   (first_cell),
        .value   (cell_val),
        .dup     (trk_dup),
        .illegal (trk_illegal)
    );

    // Value legality only needs one pass, so it is judged in the row phase alone.
    assign illegal_here = (state_q == ST_ROWS) &&
                          (trk_illegal || ((cell_val == '0) && full_q));
    assign viol         = scanning && (trk_dup || illegal_here);

    always_comb begin
        kind_d = ERR_BOX;
        if (illegal_here) begin
            kind_d = ERR_VALUE;
        end else if (state_q == ST_ROWS) begin
            kind_d = ERR_ROW;
        end else if (state_q == ST_COLS) begin
            kind_d = ERR_COL;
        end
    end

    // ---- control FSM ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_FINISH: begin
                if (check_start) state_d = ST_ROWS;
            end
            ST_ROWS: begin
                if (viol)           state_d = ST_FINISH;
                else if (last_cell) state_d = ST_COLS;
            end
            ST_COLS: begin
                if (viol)           state_d = ST_FINISH;
                else if (last_cell) state_d = ST_BOXES;
            end
            ST_BOXES: begin
                if (viol || last_cell) state_d = ST_FINISH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        scanning   = (state_q == ST_ROWS) || (state_q == ST_COLS) || (state_q == ST_BOXES);
        busy       = scanning;
        done       = (state_q == ST_FINISH);
        load_ready = !scanning;
    end

    // ---- result capture ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q     <= 1'b0;
            error_q    <= 1'b0;
            err_kind_q <= ERR_ROW;
            err_row_q  <= '0;
            err_col_q  <= '0;
        end else if (start_ok) begin
            full_q     <= check_full;
            error_q    <= 1'b0;
            err_kind_q <= ERR_ROW;
            err_row_q  <= '0;
            err_col_q  <= '0;
        end else if (viol) begin
            error_q    <= 1'b1;
            err_kind_q <= kind_d;
            err_row_q  <= scan_row;
            err_col_q  <= scan_col;
        end
    end

    assign error    = error_q;
    assign err_kind = err_kind_q;
    assign err_row  = err_row_q;
    assign err_col  = err_col_q;

endmodule
